// File: rtl/inst_fetch_buf_if.sv
// Fetch buffer bus bundle: icache request/response, redirect inputs and decode slots.
// The master modport is the fetch buffer; the slave modport is its environment.
interface inst_fetch_buf_if #(
    parameter int unsigned N_FETCH = 2,
    parameter int unsigned N_ISSUE = 2
);
    localparam int unsigned ISSUE_W = $clog2(N_ISSUE + 1);

    logic                     ibus_ready;
    logic                     ibus_read;
    logic [31:0]              ibus_vaddr;
    logic                     ibus_valid;
    logic [32*N_FETCH-1:0]    ibus_rddata;

    logic                     branch_valid;
    logic [31:0]              branch_target;
    logic                     except_valid;
    logic [31:0]              except_vec;

    logic [N_ISSUE-1:0]       if_valid;
    logic [32*N_ISSUE-1:0]    if_vaddr;
    logic [32*N_ISSUE-1:0]    if_inst;
    logic [ISSUE_W-1:0]       issue_cnt;

    modport master (
        input  ibus_ready, ibus_valid, ibus_rddata,
        input  branch_valid, branch_target, except_valid, except_vec,
        input  issue_cnt,
        output ibus_read, ibus_vaddr,
        output if_valid, if_vaddr, if_inst
    );

    modport slave (
        output ibus_ready, ibus_valid, ibus_rddata,
        output branch_valid, branch_target, except_valid, except_vec,
        output issue_cnt,
        input  ibus_read, ibus_vaddr,
        input  if_valid, if_vaddr, if_inst
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues block-aligned icache requests (one outstanding at a time),
// queues returned words in a circular FIFO and presents up to N_ISSUE slots to decode.
// Optional INST_FETCH_BUF_BYPASS_EN: a live response arriving while the queue is empty is
// shown on the decode slots in the same cycle.
module inst_fetch_buf #(
    parameter logic [31:0] BOOT_VEC    = 32'hbfc00000,
    parameter int unsigned N_FETCH     = 2,
    parameter int unsigned N_ISSUE     = 2,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_buf_if.master bus
);
    localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned BLK_BYTES = N_FETCH * 4;
    localparam logic [31:0] BLK_MASK  = ~(32'(BLK_BYTES) - 32'd1);

    logic [31:0]      q_vaddr [QUEUE_DEPTH];
    logic [31:0]      q_inst  [QUEUE_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    // live_q: a request whose response will be used; stale_q: one whose response is dropped
    logic             live_q, live_d;
    logic             stale_q, stale_d;

    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             resp_any;
    logic             resp_live;
    logic [31:0]      blk_base;
    logic [31:0]      next_blk;
    logic [CNT_W-1:0] resp_off;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] pop;
    logic [CNT_W-1:0] free_after;
    logic             can_req;
    logic             fire;
    logic             wr_en  [N_FETCH];
    logic [PTR_W-1:0] wr_idx [N_FETCH];

    // Response bookkeeping, request generation and queue write decode
    always_comb begin
        redirect    = bus.except_valid | bus.branch_valid;
        redirect_pc = bus.except_valid ? bus.except_vec : bus.branch_target;
        resp_any    = bus.ibus_valid & (live_q | stale_q);
        resp_live   = bus.ibus_valid & live_q;
        blk_base    = fetch_pc_q & BLK_MASK;
        next_blk    = blk_base + 32'(BLK_BYTES);
        // Words below the fetch PC within the block are skipped
        resp_off    = CNT_W'((fetch_pc_q - blk_base) >> 2);
        wcnt        = resp_live ? (CNT_W'(N_FETCH) - resp_off) : '0;
        pop         = CNT_W'(bus.issue_cnt);
        // Space left once this cycle's pops and writes land; never negative by construction
        free_after  = CNT_W'(QUEUE_DEPTH) - count_q + pop - wcnt;
        can_req     = ~(live_q | stale_q) | resp_any;
        bus.ibus_read  = ~rst & can_req & (free_after >= CNT_W'(N_FETCH));
        bus.ibus_vaddr = rst ? '0 : ((resp_live ? next_blk : fetch_pc_q) & BLK_MASK);
        fire        = bus.ibus_read & bus.ibus_ready;
        for (int k = 0; k < N_FETCH; k++) begin
            wr_en[k]  = resp_live && (CNT_W'(k) >= resp_off);
            wr_idx[k] = tail_q + PTR_W'(CNT_W'(k) - resp_off);
        end
    end

    // Next-state for pointers, occupancy, fetch PC and outstanding-request tracking
    always_comb begin
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(wcnt);
        count_d    = count_q - pop + wcnt;
        fetch_pc_d = resp_live ? next_blk : fetch_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        if (resp_any) begin
            live_d  = 1'b0;
            stale_d = 1'b0;
        end
        if (redirect) begin
            stale_d    = stale_d | live_d;
            live_d     = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end
        // A request accepted in the redirect cycle belongs to the old stream
        if (fire) begin
            live_d  = ~redirect;
            stale_d = redirect;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= BOOT_VEC;
            live_q     <= 1'b0;
            // Anything still in flight across reset must be discarded when it returns
            stale_q    <= (live_q | stale_q) & ~resp_any;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
        end
    end

    // Queue storage; contents past count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_FETCH; k++) begin
            if (wr_en[k]) begin
                q_vaddr[wr_idx[k]] <= blk_base + 32'(4 * k);
                q_inst[wr_idx[k]]  <= bus.ibus_rddata[32*k +: 32];
            end
        end
    end

    // Decode slot view: slot i shows entry head+i, or the bypassed response when empty
    always_comb begin
        bus.if_valid = '0;
        bus.if_vaddr = '0;
        bus.if_inst  = '0;
        for (int i = 0; i < N_ISSUE; i++) begin
            if (!rst && (CNT_W'(i) < count_q)) begin
                bus.if_valid[i]          = 1'b1;
                bus.if_vaddr[32*i +: 32] = q_vaddr[head_q + PTR_W'(i)];
                bus.if_inst[32*i +: 32]  = q_inst[head_q + PTR_W'(i)];
            end
`ifdef INST_FETCH_BUF_BYPASS_EN
            else if (!rst && (count_q == '0) && resp_live && (CNT_W'(i) < wcnt)) begin
                bus.if_valid[i] = 1'b1;
                for (int k = 0; k < N_FETCH; k++) begin
                    if (CNT_W'(k) == resp_off + CNT_W'(i)) begin
                        bus.if_vaddr[32*i +: 32] = blk_base + 32'(4 * k);
                        bus.if_inst[32*i +: 32]  = bus.ibus_rddata[32*k +: 32];
                    end
                end
            end
`endif
        end
    end
endmodule
